// File: rtl/prio_enc_arb.sv
// prio_enc_arb: registered priority encoder / arbiter.
//
// Picks one active line of req, either by fixed priority (highest index wins)
// or round-robin (the last granted index drops to lowest priority). The
// winner is registered and held as index + one-hot under a valid/ready
// handshake. A completed handshake can load the next winner in the same
// cycle, so grants can run back to back with no bubble.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         allows a new grant to start
//   mode       0 = fixed priority, 1 = round-robin
//   req        request vector, bit i = requester i active
//   out_ready  consumer accepts the current grant
//   out_valid  grant present
//   out_idx    granted index (holds its last value while invalid)
//   out_onehot one-hot grant, zero while invalid
module prio_enc_arb #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     oh_q, oh_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic             load;
  logic [IDX_W-1:0] base;
  logic [N-1:0]     low;
  logic [N-1:0]     pick;
  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     win_oh;

  assign load = en & (|req);

  // At a handshake the grant being completed becomes the new last-grant, so
  // the round-robin base must already be idx_q rather than the stale last_q.
  assign base = (state_q == StHold) ? idx_q : last_q;

  // Round-robin order is base-1 down to 0, then N-1 down to base. That equals
  // fixed priority over the requests below base, falling back to fixed
  // priority over the whole vector when none are pending there.
  always_comb begin
    low  = '0;
    pick = req;
    if (mode) begin
      for (int i = 0; i < N; i++) begin
        low[i] = req[i] & (IDX_W'(i) < base);
      end
      if (|low) pick = low;
    end
    win_idx = '0;
    win_oh  = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        win_idx   = IDX_W'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          valid_d = 1'b1;
          idx_d   = win_idx;
          oh_d    = win_oh;
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          last_d = idx_q;
          if (load) begin
            idx_d = win_idx;
            oh_d  = win_oh;
          end else begin
            valid_d = 1'b0;
            oh_d    = '0;
            state_d = StIdle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      idx_q   <= '0;
      oh_q    <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      last_q  <= last_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_onehot = oh_q;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Bench for prio_enc_arb: directed vector table on an N=8 instance plus a
// random sweep of N=2, 5 and 16 instances against a behavioural model.
module tb_prio_enc_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- N=8 directed instance ----------------
  logic       t_rst, t_en, t_mode, t_rdy;
  logic [7:0] t_req;
  logic       t_valid;
  logic [2:0] t_idx;
  logic [7:0] t_oh;

  prio_enc_arb #(.N(8)) dut8 (
    .clk        (clk),
    .rst        (t_rst),
    .en         (t_en),
    .mode       (t_mode),
    .req        (t_req),
    .out_ready  (t_rdy),
    .out_valid  (t_valid),
    .out_idx    (t_idx),
    .out_onehot (t_oh)
  );

  // ---------------- sweep instances ----------------
  logic        r_rst, r_en, r_mode, r_rdy;
  logic [15:0] r_req;
  logic        o2_valid, o5_valid, o16_valid;
  logic [0:0]  o2_idx;
  logic [2:0]  o5_idx;
  logic [3:0]  o16_idx;
  logic [1:0]  o2_oh;
  logic [4:0]  o5_oh;
  logic [15:0] o16_oh;

  prio_enc_arb #(.N(2)) dut2 (
    .clk(clk), .rst(r_rst), .en(r_en), .mode(r_mode), .req(r_req[1:0]),
    .out_ready(r_rdy), .out_valid(o2_valid), .out_idx(o2_idx), .out_onehot(o2_oh)
  );
  prio_enc_arb #(.N(5)) dut5 (
    .clk(clk), .rst(r_rst), .en(r_en), .mode(r_mode), .req(r_req[4:0]),
    .out_ready(r_rdy), .out_valid(o5_valid), .out_idx(o5_idx), .out_onehot(o5_oh)
  );
  prio_enc_arb #(.N(16)) dut16 (
    .clk(clk), .rst(r_rst), .en(r_en), .mode(r_mode), .req(r_req),
    .out_ready(r_rdy), .out_valid(o16_valid), .out_idx(o16_idx), .out_onehot(o16_oh)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, en, mode;
    logic [7:0] req;
    logic       rdy;
    logic       ev;
    int         eidx;
    logic [7:0] eoh;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic e, input logic m,
                              input logic [7:0] rq, input logic rd,
                              input logic ev, input int ei, input logic [7:0] eo);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.req = rq; v.rdy = rd;
    v.ev = ev; v.eidx = ei; v.eoh = eo;
    tbl.push_back(v);
  endfunction

  // Reference winner: explicit search order, written independently of the RTL.
  function automatic int winner(input logic [15:0] rq, input int n, input logic md,
                                input int last);
    if (!md) begin
      for (int c = n - 1; c >= 0; c--) begin
        if (rq[c]) return c;
      end
    end else begin
      for (int k = 1; k <= n; k++) begin
        int c;
        c = (last - k + n) % n;
        if (rq[c]) return c;
      end
    end
    return -1;
  endfunction

  // Model state per sweep instance: 0 -> N=2, 1 -> N=5, 2 -> N=16.
  logic mv[3];
  int   midx[3];
  int   mlast[3];

  task automatic model_step(input int k, input int n);
    logic [15:0] rq;
    rq = r_req & 16'((32'd1 << n) - 1);
    if (r_rst) begin
      mv[k] = 1'b0; midx[k] = 0; mlast[k] = 0;
    end else if (!mv[k]) begin
      if (r_en && rq != 0) begin
        midx[k] = winner(rq, n, r_mode, mlast[k]);
        mv[k]   = 1'b1;
      end
    end else if (r_rdy) begin
      mlast[k] = midx[k];
      if (r_en && rq != 0) midx[k] = winner(rq, n, r_mode, mlast[k]);
      else mv[k] = 1'b0;
    end
  endtask

  task automatic sweep_check(input int k, input int n, input logic v, input int idx,
                             input logic [15:0] oh);
    logic [15:0] eoh;
    eoh = mv[k] ? (16'd1 << midx[k]) : 16'd0;
    chk($sformatf("n%0d valid", n), int'(v), int'(mv[k]));
    chk($sformatf("n%0d idx", n), idx, midx[k]);
    chk($sformatf("n%0d onehot", n), int'(oh), int'(eoh));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // rst en mode req rdy | valid idx onehot
    add(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    // fixed-priority first grant, held while req changes
    add(0, 1, 0, 8'h26, 0, 1, 5, 8'h20);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 8'h01, 0, 1, 5, 8'h20);
    add(0, 1, 0, 8'h01, 1, 1, 0, 8'h01);
    // fixed back-to-back: 7 always wins, 0 starves
    for (int i = 0; i < 3; i++) add(0, 1, 0, 8'h81, 1, 1, 7, 8'h80);
    // round-robin from reset: 7..0 then wrap to 7
    add(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      int g;
      g = (i == 8) ? 7 : 7 - i;
      add(0, 1, 1, 8'hFF, 1, 1, g, 8'(1 << g));
    end
    for (int g = 6; g >= 3; g--) add(0, 1, 1, 8'hFF, 1, 1, g, 8'(1 << g));
    add(0, 1, 1, 8'h09, 1, 1, 0, 8'h01);
    add(0, 1, 1, 8'h09, 1, 1, 3, 8'h08);
    // enable gating; dropping en during HOLD keeps the grant until accepted
    add(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(0, 0, 0, 8'hFF, 0, 0, 0, 8'h00);
    add(0, 0, 0, 8'hFF, 0, 0, 0, 8'h00);
    add(0, 1, 0, 8'hFF, 0, 1, 7, 8'h80);
    add(0, 0, 0, 8'hFF, 0, 1, 7, 8'h80);
    add(0, 0, 0, 8'hFF, 0, 1, 7, 8'h80);
    add(0, 0, 0, 8'hFF, 1, 0, 7, 8'h00);
    add(0, 0, 0, 8'hFF, 0, 0, 7, 8'h00);
    // req=0 never grants
    add(0, 1, 0, 8'h00, 0, 0, 7, 8'h00);
    // sticky grant after the request drops
    add(0, 1, 0, 8'h04, 0, 1, 2, 8'h04);
    add(0, 1, 0, 8'h00, 0, 1, 2, 8'h04);
    add(0, 1, 0, 8'h00, 1, 0, 2, 8'h00);
    // mode sampled only at selection (L=2: round-robin picks 1, fixed picks 2)
    add(0, 1, 1, 8'h06, 0, 1, 1, 8'h02);
    add(0, 1, 0, 8'h06, 0, 1, 1, 8'h02);
    add(0, 1, 0, 8'h06, 1, 1, 2, 8'h04);
    // reset during HOLD (idx=4, L=6) with a handshake in the same cycle
    add(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(0, 1, 1, 8'hFF, 1, 1, 7, 8'h80);
    add(0, 1, 1, 8'hFF, 1, 1, 6, 8'h40);
    add(0, 1, 1, 8'hDF, 1, 1, 4, 8'h10);
    add(0, 1, 1, 8'hFF, 0, 1, 4, 8'h10);
    add(1, 1, 1, 8'hFF, 1, 0, 0, 8'h00);
    add(0, 1, 1, 8'hFF, 0, 1, 7, 8'h80);

    r_rst = 1'b1; r_en = 1'b0; r_mode = 1'b0; r_rdy = 1'b0; r_req = '0;

    foreach (tbl[i]) begin
      t_rst = tbl[i].rst; t_en = tbl[i].en; t_mode = tbl[i].mode;
      t_req = tbl[i].req; t_rdy = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d valid", i), int'(t_valid), int'(tbl[i].ev));
      chk($sformatf("vec%0d idx", i), int'(t_idx), tbl[i].eidx);
      chk($sformatf("vec%0d onehot", i), int'(t_oh), int'(tbl[i].eoh));
    end

    // Long fixed-mode back-to-back run: valid every cycle, always index 7.
    t_rst = 1'b1; t_en = 1'b0; t_mode = 1'b0; t_req = 8'h00; t_rdy = 1'b0;
    @(posedge clk);
    #1;
    t_rst = 1'b0; t_en = 1'b1; t_req = 8'h81; t_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d valid", i), int'(t_valid), 1);
      chk($sformatf("b2b%0d idx", i), int'(t_idx), 7);
    end

    // Random sweep on N=2/5/16, all driven by the same stimulus.
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; midx[k] = 0; mlast[k] = 0;
    end
    for (int c = 0; c < 2000; c++) begin
      r_rst  = (c < 2) || ($urandom_range(99) < 2);
      r_en   = ($urandom_range(99) < 85);
      r_mode = $urandom_range(1) == 1;
      r_rdy  = $urandom_range(1) == 1;
      r_req  = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
      @(posedge clk);
      model_step(0, 2);
      model_step(1, 5);
      model_step(2, 16);
      #1;
      sweep_check(0, 2, o2_valid, int'(o2_idx), 16'(o2_oh));
      sweep_check(1, 5, o5_valid, int'(o5_idx), 16'(o5_oh));
      sweep_check(2, 16, o16_valid, int'(o16_idx), o16_oh);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
